clint_rtc_tick: RTL and testbench

//  Timebase front-end for the CLINT. Synchronises the external real-time clock (rt_clk, typ. 32.768 kHz)

---
 rtl/clint_pkg.sv | 20 ++
 rtl/clint_sync.sv | 21 ++
 rtl/clint_rtc_tick.sv | 98 +++++++++
 tb/tb_clint_rtc_tick.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT constants: register map, timebase defaults and
// increment-interface widths used by the tick front-end and mtime stage.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_PRESC_W     = 16;

  localparam int INC_CNT_W = DEF_CNT_W;

  typedef struct packed {
    logic                 valid;
    logic [INC_CNT_W-1:0] count;
  } inc_t;

endpackage

// File: rtl/clint_sync.sv
// Parametric flop-chain synchroniser for asynchronous timer inputs.
// Ports: clk, reset (async active-low), d (async in), q (synchronised out).
module clint_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clint_rtc_tick.sv
// CLINT timebase front-end: rt_clk edges (or the optional prescaler when
// CLINT_RTC_PRESCALER_EN is defined) become ticks accumulated for mtime.
// Ports: clk, reset (async active-low), rt_clk, en, src_sel, presc_div,
// inc_valid/inc_count/inc_ready (increment handshake), ovf, ovf_clr.
module clint_rtc_tick
  import clint_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PRESC_W     = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rt_clk,
  input  logic               en,
  input  logic               src_sel,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               inc_valid,
  output logic [CNT_W-1:0]   inc_count,
  input  logic               inc_ready,
  output logic               ovf,
  input  logic               ovf_clr
);

  logic             rt_s;
  logic             prev;
  logic             ev_rtc;
  logic             ev;
  logic             hs;
  logic [CNT_W-1:0] acc;

  clint_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rt_clk),
    .q    (rt_s)
  );

  // ev_rtc is registered so a rise reaches it SYNC_STAGES+1 cycles later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev   <= 1'b0;
      ev_rtc <= 1'b0;
    end else begin
      prev   <= rt_s;
      ev_rtc <= rt_s & ~prev;
    end
  end

`ifdef CLINT_RTC_PRESCALER_EN
  logic [PRESC_W-1:0] pc;
  logic               presc_on;
  logic               ev_presc;

  assign presc_on = en & src_sel & (presc_div != '0);
  // >= so that lowering presc_div below pc wraps at once
  assign ev_presc = presc_on & (pc >= presc_div - PRESC_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc <= '0;
    else if (!presc_on) pc <= '0;
    else if (ev_presc)  pc <= '0;
    else                pc <= pc + PRESC_W'(1);
  end

  assign ev = en & (src_sel ? ev_presc : ev_rtc);
`else
  logic unused_presc;
  assign unused_presc = ^{src_sel, presc_div};
  assign ev = en & ev_rtc;
`endif

  assign hs = inc_valid & inc_ready;

  // a tick coinciding with a handshake restarts the count at 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (hs) begin
      acc <= {{(CNT_W-1){1'b0}}, ev};
    end else if (ev && (acc != '1)) begin
      acc <= acc + CNT_W'(1);
    end
  end

  // set wins over clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       ovf <= 1'b0;
    else if (ev && !hs && acc == '1)  ovf <= 1'b1;
    else if (ovf_clr)                 ovf <= 1'b0;
  end

  assign inc_valid = (acc != '0);
  assign inc_count = acc;

endmodule

// File: tb/tb_clint_rtc_tick.sv
// Scoreboard bench for clint_rtc_tick (CNT_W=4 to reach saturation).
// Expected increments are queued by stimulus and popped by a monitor.
module tb_clint_rtc_tick;

  localparam int SS = 2;
  localparam int CW = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          rt_clk;
  logic          en;
  logic          src_sel;
  logic [PW-1:0] presc_div;
  logic          inc_valid;
  logic [CW-1:0] inc_count;
  logic          inc_ready;
  logic          ovf;
  logic          ovf_clr;

  int vectors = 0;
  int miscompares = 0;
  int hs_seen = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  clint_rtc_tick #(
    .SYNC_STAGES(SS),
    .CNT_W      (CW),
    .PRESC_W    (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rt_clk   (rt_clk),
    .en       (en),
    .src_sel  (src_sel),
    .presc_div(presc_div),
    .inc_valid(inc_valid),
    .inc_count(inc_count),
    .inc_ready(inc_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rise();
    rt_clk = 1'b1;
    tick(3);
    rt_clk = 1'b0;
    tick(3);
  endtask

  // monitor: every handshake pops one expected inc_count
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (reset && inc_valid && inc_ready) begin
        hs_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_inc: got %0d expected none",
                   inc_count);
        end else begin
          e = exp_q.pop_front();
          chk("inc_count", int'(inc_count), e);
        end
      end
    end
  end

  initial begin
    int h0;
    reset = 1'b0;
    rt_clk = 1'b0;
    en = 1'b1;
    src_sel = 1'b0;
    presc_div = '0;
    inc_ready = 1'b1;
    ovf_clr = 1'b0;

    // 1: reset with rt_clk toggling
    #2;
    for (int i = 0; i < 3; i++) begin
      rt_clk = ~rt_clk;
      tick(3);
      chk("rst_valid", int'(inc_valid), 0);
      chk("rst_count", int'(inc_count), 0);
      chk("rst_ovf", int'(ovf), 0);
    end
    rt_clk = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(4);
    exp_q.push_back(1);
    rt_clk = 1'b1;
    tick(SS + 1);
    chk("lat_early", int'(inc_valid), 0);
    tick(1);
    chk("lat_valid", int'(inc_valid), 1);
    rt_clk = 1'b0;
    tick(4);

    // 2: ready high, 10 single pulses
    h0 = hs_seen;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(1);
      rise();
    end
    tick(2);
    chk("pulse_cnt", hs_seen - h0, 10);

    // 3: 5 rises pending, then a rise on the handshake cycle
    inc_ready = 1'b0;
    for (int i = 0; i < 5; i++) rise();
    chk("pend5", int'(inc_count), 5);
    exp_q.push_back(5);
    exp_q.push_back(1);
    rt_clk = 1'b1;
    tick(3);
    inc_ready = 1'b1;
    tick(1);
    rt_clk = 1'b0;
    tick(4);
    chk("drain3", int'(inc_valid), 0);

    // 4: saturation and ovf
    inc_ready = 1'b0;
    for (int i = 0; i < 17; i++) rise();
    chk("sat_count", int'(inc_count), 15);
    chk("sat_ovf", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);
    rt_clk = 1'b1;
    tick(3);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", int'(ovf), 1);
    rt_clk = 1'b0;
    tick(3);
    chk("sat_hold", int'(inc_count), 15);
    exp_q.push_back(15);
    inc_ready = 1'b1;
    tick(2);
    chk("sat_drain", int'(inc_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;

    // 5: en=0 discards, pending still drains, no false edge
    inc_ready = 1'b0;
    rise();
    rise();
    en = 1'b0;
    rise();
    rise();
    rt_clk = 1'b1;
    tick(6);
    chk("en0_hold", int'(inc_count), 2);
    exp_q.push_back(2);
    inc_ready = 1'b1;
    tick(2);
    chk("en0_drain", int'(inc_valid), 0);
    en = 1'b1;
    tick(6);
    chk("reen_noedge", int'(inc_valid), 0);
    rt_clk = 1'b0;
    tick(3);

`ifdef CLINT_RTC_PRESCALER_EN
    // 6: prescaler
    h0 = hs_seen;
    for (int i = 0; i < 9; i++) exp_q.push_back(1);
    presc_div = 16'd4;
    src_sel = 1'b1;
    for (int i = 0; i < 40; i++) @(negedge clk);
    src_sel = 1'b0;
    tick(2);
    chk("presc4_cnt", hs_seen - h0, 9);
    exp_q.push_back(1);
    src_sel = 1'b1;
    tick(2);
    presc_div = 16'd2;
    tick(1);
    chk("presc_wrap", int'(inc_valid), 1);
    src_sel = 1'b0;
    tick(3);
    h0 = hs_seen;
    presc_div = '0;
    src_sel = 1'b1;
    tick(20);
    chk("presc0_none", hs_seen - h0, 0);
    src_sel = 1'b0;
`else
    // src_sel ignored: rt_clk still drives ticks
    h0 = hs_seen;
    exp_q.push_back(1);
    presc_div = 16'd4;
    src_sel = 1'b1;
    rise();
    tick(2);
    chk("nopresc_rtc", hs_seen - h0, 1);
    src_sel = 1'b0;
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
